// File: rtl/iir_pkg.sv
// Shared types and helpers for the iir_seq stream sequencer.
package iir_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_RDY,
    S_IDLE,
    S_START,
    S_BUSY
  } iir_seq_state_t;

  // FIFO pointer width for a power-of-two depth.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/iir_seq_fifo.sv
// Synchronous FIFO with exact full/empty flags and a synchronous flush.
module iir_seq_fifo
  import iir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTRW = fifo_ptr_w(DEPTH);
  localparam int CW   = PTRW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Flush wins over a simultaneous push or pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/iir_seq.sv
// Stream sequencer: buffers samples, issues them one at a time to an iir
// core, captures results into a single-entry output register, and owns the
// core's reset, flush and hang detection.
module iir_seq
  import iir_pkg::*;
#(
  parameter int OPSIZE     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNTW       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OPSIZE-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OPSIZE-1:0] m_data,
  output logic              core_start,
  output logic              core_reset,
  output logic [OPSIZE-1:0] core_xin,
  input  logic [OPSIZE-1:0] core_yout,
  input  logic              core_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic [CNTW-1:0]   sample_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]        rst_sync;
  logic              rst_n;
  iir_seq_state_t    state;
  iir_seq_state_t    state_next;
  logic              full;
  logic              empty;
  logic [OPSIZE-1:0] head;
  logic              load_xin;
  logic              pop;
  logic              capture;
  logic              timeout;
  logic              seen_low;
  logic [TW-1:0]     tcnt;

  // Reset asserts asynchronously, releases after two clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  iir_seq_fifo #(
    .WIDTH(OPSIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .push (s_valid),
    .pop  (pop),
    .din  (s_data),
    .head (head),
    .full (full),
    .empty(empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  // Next-state logic and per-cycle strobes; flush overrides everything.
  always_comb begin
    state_next = state;
    load_xin   = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_INIT:     state_next = S_WAIT_RDY;
      S_WAIT_RDY: if (core_ready) state_next = S_IDLE;
      S_IDLE: begin
        if (!empty && !m_valid && core_ready) begin
          load_xin   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        pop        = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        // A capture in the final timeout cycle still counts as a capture.
        if (core_ready && seen_low) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = S_INIT;
        end
      end
      default: state_next = S_INIT;
    endcase
    if (flush) begin
      state_next = S_INIT;
      load_xin   = 1'b0;
      pop        = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
    end
  end

  // BUSY bookkeeping: ready must drop before a rising ready is a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_low <= 1'b0;
      tcnt     <= '0;
    end else if (state == S_START) begin
      seen_low <= 1'b0;
      tcnt     <= '0;
    end else if (state == S_BUSY) begin
      if (!core_ready) seen_low <= 1'b1;
      tcnt <= tcnt + TW'(1);
    end
  end

  // Core operand, output register, error flag and result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_xin    <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      err_timeout <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      if (load_xin) core_xin <= head;
      if (flush) begin
        m_valid     <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (capture) begin
          m_data     <= core_yout;
          m_valid    <= 1'b1;
          sample_cnt <= sample_cnt + CNTW'(1);
        end else if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
        if (timeout) err_timeout <= 1'b1;
      end
    end
  end

  assign s_ready    = !full;
  assign core_reset = (state == S_INIT);
  assign core_start = (state == S_START);
  assign busy       = (state == S_START) || (state == S_BUSY);

endmodule
